// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hazard_ctrl_if                                              |
// | Description : Hazard-controller bundle between the pipeline datapath      |
// |               (master) and the hazard controller (slave).                 |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
interface hazard_ctrl_if #(
  parameter int REG_W = 5
);
  // Hazard sources observed in the ID, EX and MEM stages
  logic [REG_W-1:0] RsD;
  logic [REG_W-1:0] RtD;
  logic [REG_W-1:0] RtE;
  logic             MemReadE;
  logic             BranchTakenD;
  logic             JumpD;
  logic             MemReqM;
  logic             MemReadyM;

  // Pipeline-register and PC controls
  logic             PC_Stall;
  logic             IF_Stall;
  logic             IF_Flush;
  logic             ID_EX_Stall;
  logic             ID_EX_Flush;
  logic             EX_MEM_Stall;
  logic             MemTimeout;

  modport master (
    output RsD, RtD, RtE, MemReadE, BranchTakenD, JumpD, MemReqM, MemReadyM,
    input  PC_Stall, IF_Stall, IF_Flush, ID_EX_Stall, ID_EX_Flush,
           EX_MEM_Stall, MemTimeout
  );

  modport slave (
    input  RsD, RtD, RtE, MemReadE, BranchTakenD, JumpD, MemReqM, MemReadyM,
    output PC_Stall, IF_Stall, IF_Flush, ID_EX_Stall, ID_EX_Flush,
           EX_MEM_Stall, MemTimeout
  );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hazard_ctrl                                                 |
// | Description : 5-stage pipeline hazard controller. Resolves load-use       |
// |               hazards, branch/jump redirects and multi-cycle data-memory  |
// |               waits (with timeout). Optional performance counters are     |
// |               enabled by defining HAZARD_PERF_CNT_EN.                     |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module hazard_ctrl #(
  parameter int REG_W       = 5,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input wire           clk,
  input wire           rst,
  hazard_ctrl_if.slave bus
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]  StallCycles,
  output logic [31:0]  FlushCount
`endif
);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [REG_W-1:0] c_ZERO_REG  = '0;
  // Last wait-counter value before the access is abandoned
  localparam logic [CNT_W-1:0] c_WCNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_wcnt;
  logic [CNT_W-1:0] w_wcnt_nxt;
  logic             r_timeout;
  logic             w_timeout_nxt;
  logic             w_lu;
  logic             w_mw;
  logic             w_redirect;

  // Hazard detection terms; a load into r0 never creates a dependency
  always_comb begin
    w_lu       = bus.MemReadE && (bus.RtE != c_ZERO_REG) &&
                 ((bus.RtE == bus.RsD) || (bus.RtE == bus.RtD));
    w_mw       = (r_state == MEM_WAIT) || (bus.MemReqM && !bus.MemReadyM);
    w_redirect = bus.BranchTakenD || bus.JumpD;
  end

  // Prioritised same-cycle control outputs: rst > memory wait > load-use > redirect
  always_comb begin
    bus.PC_Stall     = 1'b0;
    bus.IF_Stall     = 1'b0;
    bus.IF_Flush     = 1'b0;
    bus.ID_EX_Stall  = 1'b0;
    bus.ID_EX_Flush  = 1'b0;
    bus.EX_MEM_Stall = 1'b0;
    bus.MemTimeout   = r_timeout;
    if (rst) begin
      bus.IF_Flush    = 1'b1;
      bus.ID_EX_Flush = 1'b1;
    end else if (w_mw) begin
      bus.PC_Stall     = 1'b1;
      bus.IF_Stall     = 1'b1;
      bus.ID_EX_Stall  = 1'b1;
      bus.EX_MEM_Stall = 1'b1;
    end else if (w_lu) begin
      // A redirect seen here is dropped; ID re-presents it after the stall
      bus.PC_Stall    = 1'b1;
      bus.IF_Stall    = 1'b1;
      bus.ID_EX_Flush = 1'b1;
    end else if (w_redirect) begin
      bus.IF_Flush = 1'b1;
    end
  end

  // Memory-wait FSM next state, wait counter and sticky timeout
  always_comb begin
    w_state_nxt   = r_state;
    w_wcnt_nxt    = r_wcnt;
    w_timeout_nxt = r_timeout;
    case (r_state)
      RUN: begin
        if (bus.MemReqM && !bus.MemReadyM) begin
          w_state_nxt = MEM_WAIT;
          w_wcnt_nxt  = '0;
        end
      end
      MEM_WAIT: begin
        if (bus.MemReadyM) begin
          w_state_nxt = RUN;
        end else if (r_wcnt == c_WCNT_LAST) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = RUN;
        end else begin
          w_wcnt_nxt = r_wcnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  // FSM state register; reset aborts any in-flight wait
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RUN;
      r_wcnt    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wcnt    <= w_wcnt_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_count;

  // Free-running performance counters, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (bus.PC_Stall) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (bus.IF_Flush) r_flush_count  <= r_flush_count + 32'd1;
    end
  end

  assign StallCycles = r_stall_cycles;
  assign FlushCount  = r_flush_count;
`endif

endmodule
`default_nettype wire
